mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Registers the execute-to-memory bus under stall/bubble control.
- Aligns and extends load data returned by the synchronous data SRAM, and selects the register write-back value.
- Drives the write-back bus and the MEM-stage forwarding bus to the register file.
- Buffers SRAM read data so a load held in MEM across stall cycles keeps the value it originally read.

---
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, aligns/extends load data, drives WB and forwarding buses.
// Latency: one register stage from EX; outputs are combinational from that register and SRAM read data.
// Backpressure: stall[3] holds the stage (read data is latched on the first held edge); stall[3] without stall[4] bubbles.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 81,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    load_addr_err
);

  typedef struct packed {
    logic [4:0]  mem_op;      // one-hot: LB, LBU, LH, LHU, LW
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  ex_mem_t     bus_r;
  logic        hold_vld;
  logic [31:0] rdata_hold;

  // The stage moves on (new instruction or bubble) unless both MEM and WB are stopped.
  logic advance;
  logic bubble;
  assign bubble  = stall[3] & ~stall[4];
  assign advance = ~stall[3] | bubble;

  // Pipeline register: bubble has priority over load, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r <= '0;
    end else if (bubble) begin
      bus_r <= '0;
    end else if (!stall[3]) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  // Capture SRAM read data on the first held edge so a stalled load keeps its original value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld   <= 1'b0;
      rdata_hold <= '0;
    end else if (advance) begin
      hold_vld   <= 1'b0;
    end else if (!hold_vld) begin
      rdata_hold <= data_sram_rdata;
      hold_vld   <= 1'b1;
    end
  end

  logic [31:0] rd;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        rf_we_eff;
  logic [31:0] rf_wdata;

  assign rd = hold_vld ? rdata_hold : data_sram_rdata;
  assign a  = bus_r.ex_result[1:0];

  // Little-endian byte/halfword selection and sign/zero extension.
  always_comb begin
    byte_sel  = rd[7:0];
    half_sel  = a[1] ? rd[31:16] : rd[15:0];
    load_data = '0;
    case (a)
      2'd0: byte_sel = rd[7:0];
      2'd1: byte_sel = rd[15:8];
      2'd2: byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    if (bus_r.mem_op[4]) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (bus_r.mem_op[3]) begin
      load_data = {24'd0, byte_sel};
    end else if (bus_r.mem_op[2]) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (bus_r.mem_op[1]) begin
      load_data = {16'd0, half_sel};
    end else if (bus_r.mem_op[0]) begin
      load_data = rd;
    end
  end

  // Misaligned halfword/word loads are flagged and suppress the register write.
  assign load_addr_err = ((bus_r.mem_op[2] | bus_r.mem_op[1]) & a[0]) |
                         (bus_r.mem_op[0] & (|a));
  assign rf_we_eff     = bus_r.rf_we & ~load_addr_err;
  assign rf_wdata      = bus_r.sel_rf_res ? load_data : bus_r.ex_result;

  assign mem_to_rf_bus = {rf_we_eff, bus_r.rf_waddr, rf_wdata};
  assign mem_to_wb_bus = {bus_r.ex_pc, mem_to_rf_bus};

  // Store enables and stall bits owned by other stages are not needed here.
  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[2:0], bus_r.data_ram_en, bus_r.data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan cases plus randomized traffic against a behavioural model.
// The model tracks the instruction resident in MEM and the read data it first saw.
// Inputs change on the falling edge; outputs are compared 2 time units later.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [80:0] ex_bus;
  logic [31:0] rdata;
  logic [69:0] wb;
  logic [37:0] rf;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011111;
  localparam logic [5:0] BUB  = 6'b001000;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_to_mem_bus(ex_bus),
    .data_sram_rdata(rdata), .mem_to_wb_bus(wb), .mem_to_rf_bus(rf),
    .load_addr_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc,
                                     input logic [3:0] wen, input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, (op != 5'd0) || (wen != 4'd0), wen, sel, we, wa, res};
  endfunction

  // Expected {load_addr_err, mem_to_wb_bus} for an instruction and the read data it uses.
  function automatic logic [70:0] expect_out(input logic [80:0] b, input logic [31:0] rd);
    logic [4:0]  op;
    logic [1:0]  a;
    logic [31:0] by, hw, ld;
    logic        e, we;
    op = b[80:76];
    a  = b[1:0];
    by = (rd >> (8 * a)) & 32'hFF;
    hw = (rd >> (16 * a[1])) & 32'hFFFF;
    case (op)
      5'b10000: ld = by[7]  ? (by | 32'hFFFFFF00) : by;
      5'b01000: ld = by;
      5'b00100: ld = hw[15] ? (hw | 32'hFFFF0000) : hw;
      5'b00010: ld = hw;
      5'b00001: ld = rd;
      default:  ld = 32'd0;
    endcase
    e  = ((op == 5'b00100 || op == 5'b00010) && a[0]) || (op == 5'b00001 && a != 2'd0);
    we = b[37] && !e;
    return {e, b[75:44], we, b[36:32], b[38] ? ld : b[31:0]};
  endfunction

  // Model: which instruction sits in MEM, how many edges it has been held, and its first read data.
  logic [80:0] m_bus;
  int          m_age;
  logic [31:0] m_cap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bus = '0;
      m_age = 0;
      m_cap = '0;
    end else if (!stall[3]) begin
      m_bus = ex_bus;
      m_age = 0;
    end else if (!stall[4]) begin
      m_bus = '0;
      m_age = 0;
    end else begin
      if (m_age == 0) m_cap = rdata;
      m_age++;
    end
  end

  task automatic drive(input logic [5:0] st, input logic [80:0] b, input logic [31:0] r);
    logic [70:0] exp;
    @(negedge clk);
    stall  = st;
    ex_bus = b;
    rdata  = r;
    #2;
    if (!rst) begin
      exp = expect_out(m_bus, (m_age > 0) ? m_cap : rdata);
      chk("model_wb", wb, exp[69:0]);
      chk("model_rf", {32'd0, rf}, {32'd0, exp[37:0]});
      chk("model_err", {69'd0, err}, {69'd0, exp[70]});
    end
  endtask

  logic [4:0] ops [6] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  initial begin
    rst    = 1'b1;
    stall  = RUN;
    ex_bus = '0;
    rdata  = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_wb", wb, 70'd0);
    chk("reset_rf", {32'd0, rf}, 70'd0);
    chk("reset_err", {69'd0, err}, 70'd0);
    @(negedge clk);
    rst = 1'b0;

    // LW aligned
    drive(RUN, mk(5'b00001, 32'h00400010, 4'd0, 1'b1, 1'b1, 5'd5, 32'h1000), 32'h0);
    drive(RUN, mk(5'b10000, 32'h00400014, 4'd0, 1'b1, 1'b1, 5'd6, 32'h1003), 32'hDEADBEEF);
    chk("lw_wb_low", {32'd0, wb[37:0]}, {32'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    chk("lw_rf", {32'd0, rf}, {32'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    chk("lw_pc", {38'd0, wb[69:38]}, {38'd0, 32'h00400010});
    // LB / LBU / LHU
    drive(RUN, mk(5'b01000, 32'h00400018, 4'd0, 1'b1, 1'b1, 5'd6, 32'h1003), 32'h80FF0011);
    chk("lb_wdata", {38'd0, wb[31:0]}, {38'd0, 32'hFFFFFF80});
    drive(RUN, mk(5'b00010, 32'h0040001C, 4'd0, 1'b1, 1'b1, 5'd6, 32'h1002), 32'h80FF0011);
    chk("lbu_wdata", {38'd0, wb[31:0]}, {38'd0, 32'h00000080});
    drive(RUN, '0, 32'hBEEF1234);
    chk("lhu_wdata", {38'd0, wb[31:0]}, {38'd0, 32'h0000BEEF});

    // Stalled load keeps the first read value
    drive(RUN, mk(5'b00001, 32'h00400020, 4'd0, 1'b1, 1'b1, 5'd7, 32'h2000), 32'h0);
    drive(HOLD, mk(5'b00001, 32'h00400024, 4'd0, 1'b1, 1'b1, 5'd9, 32'h3000), 32'h11111111);
    chk("stall0_wdata", {38'd0, wb[31:0]}, {38'd0, 32'h11111111});
    for (int i = 0; i < 2; i++) begin
      drive(HOLD, mk(5'b00001, 32'h00400024, 4'd0, 1'b1, 1'b1, 5'd9, 32'h3000), 32'h22222222);
      chk("stall_hold_wdata", {38'd0, wb[31:0]}, {38'd0, 32'h11111111});
    end
    drive(RUN, mk(5'b00001, 32'h00400024, 4'd0, 1'b1, 1'b1, 5'd9, 32'h3000), 32'h22222222);
    chk("stall_release_wdata", {38'd0, wb[31:0]}, {38'd0, 32'h11111111});
    drive(RUN, '0, 32'h33333333);
    chk("after_release_live", {32'd0, wb[37:0]}, {32'd0, 1'b1, 5'd9, 32'h33333333});

    // Bubble
    drive(RUN, mk(5'b00001, 32'h00400028, 4'd0, 1'b1, 1'b1, 5'd3, 32'h4000), 32'h0);
    drive(BUB, mk(5'b00001, 32'h0040002C, 4'd0, 1'b1, 1'b1, 5'd4, 32'h4004), 32'h12345678);
    drive(RUN, '0, 32'h87654321);
    chk("bubble_wb", wb, 70'd0);

    // Misaligned loads
    drive(RUN, mk(5'b00100, 32'h00400030, 4'd0, 1'b1, 1'b1, 5'd8, 32'h1001), 32'h0);
    drive(RUN, mk(5'b00001, 32'h00400034, 4'd0, 1'b1, 1'b1, 5'd8, 32'h1002), 32'hCAFEF00D);
    chk("lh_mis_err", {69'd0, err}, 70'd1);
    chk("lh_mis_we", {69'd0, wb[37]}, 70'd0);
    drive(RUN, mk(5'b00010, 32'h00400038, 4'd0, 1'b1, 1'b1, 5'd8, 32'h1002), 32'hCAFEF00D);
    chk("lw_mis_err", {69'd0, err}, 70'd1);
    chk("lw_mis_we", {69'd0, rf[37]}, 70'd0);
    drive(RUN, '0, 32'hCAFEF00D);
    chk("lhu_al_err", {69'd0, err}, 70'd0);
    chk("lhu_al_we", {69'd0, wb[37]}, 70'd1);

    // Async reset while a load is held
    drive(RUN, mk(5'b00001, 32'h00400040, 4'd0, 1'b1, 1'b1, 5'd3, 32'h4000), 32'h0);
    drive(HOLD, '0, 32'hAAAA5555);
    drive(HOLD, '0, 32'h0);
    chk("held_before_rst", {38'd0, wb[31:0]}, {38'd0, 32'hAAAA5555});
    #1 rst = 1'b1;
    #1;
    chk("rst_async_wb", wb, 70'd0);
    chk("rst_async_rf", {32'd0, rf}, 70'd0);
    chk("rst_async_err", {69'd0, err}, 70'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hold_vld", {69'd0, dut.hold_vld}, 70'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  st;
      logic [4:0]  op;
      logic [3:0]  wen;
      int          r;
      r  = $urandom_range(0, 9);
      st = (r < 5) ? RUN : (r < 7) ? HOLD : (r < 8) ? 6'b010000 : BUB;
      op = ops[$urandom_range(0, 5)];
      wen = (op == 5'd0 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      drive(st, mk(op, $urandom, wen, op != 5'd0, 1'($urandom), 5'($urandom), $urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
